maxmin_streamer: RTL and testbench

MAXMIN_STREAMER -- requirements
Module: maxmin_streamer

---
 rtl/maxmin_streamer.sv | 160 ++++++++++++++++
 tb/tb_maxmin_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxmin_streamer.sv
// maxmin_streamer: streams a frame of N_SAMPLES alternating-sign multiples of
// a latched step to a downstream min/max block, then waits for its result.
// Optional result-wait timeout: define MAXMIN_STREAMER_TIMEOUT_EN.
// Handshake: valid marks each frame sample on din_out. There is no
// backpressure, so the frame occupies N_SAMPLES consecutive cycles. res_rdy
// qualifies res_in and is honoured only in WAIT. Every output is registered.
module maxmin_streamer #(
    parameter int unsigned N_SAMPLES = 16,
    parameter int unsigned WAIT_MAX  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] step,
    output logic signed [15:0] din_out,
    output logic               valid,
    input  logic        [15:0] res_in,
    input  logic               res_rdy,
    output logic        [15:0] result,
    output logic               done,
    output logic               busy,
    output logic               timeout,
    output logic        [1:0]  state_dbg_o
);

    // Reject out-of-range configurations at elaboration.
    if (N_SAMPLES < 1 || N_SAMPLES > 255) begin : g_bad_n_samples
        $error("maxmin_streamer: N_SAMPLES must be 1..255");
    end
    if (WAIT_MAX < 1 || WAIT_MAX > 65535) begin : g_bad_wait_max
        $error("maxmin_streamer: WAIT_MAX must be 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q;
    logic        [8:0]  k_q;        // index of the sample currently on din_out
    logic signed [15:0] step_q;
    logic signed [15:0] din_q;
    logic               valid_q;
    logic        [15:0] result_q;
    logic               done_q;
    logic               busy_q;
    logic        [8:0]  k_d;
    logic               last_sample;

`ifdef MAXMIN_STREAMER_TIMEOUT_EN
    logic        [15:0] wait_cnt_q;
    logic               timeout_q;
`endif

    // Sample k: +k*s for odd k, -(k*s) for even k, wrapped to 16 bits.
    function automatic logic [15:0] sample_of(input logic [8:0] k,
                                              input logic signed [15:0] s);
        logic signed [31:0] prod;
        prod = 32'(s) * $signed({23'd0, k});
        if (k[0]) begin
            return prod[15:0];
        end
        return 16'(-prod);
    endfunction

    // Next sample index and end-of-frame detect.
    always_comb begin
        k_d         = k_q + 9'd1;
        last_sample = (k_q == 9'(N_SAMPLES));
    end

    // Frame sequencer: IDLE -> SEND (N_SAMPLES cycles) -> WAIT -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            k_q      <= 9'd0;
            step_q   <= 16'sd0;
            din_q    <= 16'sd0;
            valid_q  <= 1'b0;
            result_q <= 16'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MAXMIN_STREAMER_TIMEOUT_EN
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        step_q  <= step;
                        k_q     <= 9'd1;
                        din_q   <= sample_of(9'd1, step);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
`ifdef MAXMIN_STREAMER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
                    if (last_sample) begin
                        din_q   <= 16'sd0;
                        valid_q <= 1'b0;
                        state_q <= ST_WAIT;
`ifdef MAXMIN_STREAMER_TIMEOUT_EN
                        wait_cnt_q <= 16'd0;
`endif
                    end else begin
                        k_q   <= k_d;
                        din_q <= sample_of(k_d, step_q);
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the expiry cycle still wins.
                    if (res_rdy) begin
                        result_q <= res_in;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
`ifdef MAXMIN_STREAMER_TIMEOUT_EN
                    else if (wait_cnt_q == 16'(WAIT_MAX - 1)) begin
                        result_q  <= 16'h8000;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    din_q   <= 16'sd0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign din_out     = din_q;
    assign valid       = valid_q;
    assign result      = result_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign state_dbg_o = state_q;

`ifdef MAXMIN_STREAMER_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_maxmin_streamer.sv
// Bench for maxmin_streamer: frame sample stream, result capture, ignored
// inputs, back-to-back frames, mid-frame reset and the optional timeout.
module tb_maxmin_streamer;

    localparam int N  = 16;
    localparam int WM = 10;

    logic               clk     = 1'b0;
    logic               rst     = 1'b0;
    logic               start   = 1'b0;
    logic signed [15:0] step    = 16'sd0;
    logic        [15:0] res_in  = 16'd0;
    logic               res_rdy = 1'b0;
    logic signed [15:0] din_out;
    logic               valid;
    logic        [15:0] result;
    logic               done;
    logic               busy;
    logic               timeout;
    logic        [1:0]  state_dbg;

    logic [15:0] exp_q[$];
    logic [15:0] res_q[$];
    logic [15:0] last_result = 16'd0;
    int n_cmp = 0;
    int n_err = 0;

    maxmin_streamer #(.N_SAMPLES(N), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .start(start), .step(step),
        .din_out(din_out), .valid(valid), .res_in(res_in), .res_rdy(res_rdy),
        .result(result), .done(done), .busy(busy), .timeout(timeout),
        .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_sample(input int k, input logic signed [15:0] s);
        int p;
        p = k * int'(s);
        if (k % 2 == 0) p = -p;
        return p[15:0];
    endfunction

    task automatic push_frame(input logic signed [15:0] s);
        for (int k = 1; k <= N; k++) exp_q.push_back(model_sample(k, s));
    endtask

    // Returns just after the edge that accepts start (sample 1 now on din_out).
    task automatic start_frame(input logic signed [15:0] s);
        push_frame(s);
        @(posedge clk); #1;
        start = 1'b1;
        step  = s;
        @(posedge clk); #1;
        start = 1'b0;
        step  = 16'($urandom);
    endtask

    // Checks N samples, optionally toggling start/res_rdy during SEND, and
    // returns on the negedge of the first WAIT cycle.
    task automatic check_samples(input string tag, input bit noise);
        logic [15:0] e;
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            n_cmp++;
            if (valid !== 1'b1 || din_out !== e) begin
                n_err++;
                $display("FAIL %s sample %0d: valid=%b din_out=%h, required valid=1 din_out=%h",
                         tag, i, valid, din_out, e);
            end
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s send flags %0d: busy=%b done=%b, required busy=1 done=0",
                         tag, i, busy, done);
            end
            if (noise) begin
                start   = 1'b1;
                res_rdy = 1'b1;
                res_in  = 16'hBEEF;
            end
        end
        @(negedge clk);
        start   = 1'b0;
        res_rdy = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || din_out !== 16'd0 || busy !== 1'b1 || state_dbg !== 2'd2) begin
            n_err++;
            $display("FAIL %s frame end: valid=%b din_out=%h busy=%b state=%0d, required 0 0000 1 2",
                     tag, valid, din_out, busy, state_dbg);
        end
    endtask

    // Idles `waits` more WAIT cycles, then returns result r via res_rdy.
    task automatic finish_frame(input string tag, input logic [15:0] r, input int waits);
        logic [15:0] e;
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1 || valid !== 1'b0) begin
                n_err++;
                $display("FAIL %s wait %0d: done=%b busy=%b valid=%b, required 0 1 0",
                         tag, w, done, busy, valid);
            end
        end
        res_q.push_back(r);
        res_rdy = 1'b1;
        res_in  = r;
        @(negedge clk);
        res_rdy = 1'b0;
        res_in  = 16'($urandom);
        e = res_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e || busy !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL %s capture: done=%b result=%h busy=%b timeout=%b, required 1 %h 0 0",
                     tag, done, result, busy, timeout, e);
        end
        last_result = e;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || result !== e || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s after capture: done=%b result=%h busy=%b, required 0 %h 0",
                     tag, done, result, busy, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (din_out !== 16'd0 || valid !== 1'b0 || result !== 16'd0 || done !== 1'b0 ||
            busy !== 1'b0 || timeout !== 1'b0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL reset: din=%h v=%b res=%h done=%b busy=%b to=%b st=%0d, required all 0",
                     din_out, valid, result, done, busy, timeout, state_dbg);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle without start: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_basic();
        start_frame(16'sd1);
        check_samples("basic", 1'b0);
        finish_frame("basic", 16'h001F, 3);
    endtask

    task automatic test_wrap();
        start_frame(16'sh1000);
        check_samples("wrap", 1'b0);
        finish_frame("wrap", 16'h7FFF, 1);
        start_frame(16'($urandom_range(0, 65535)));
        check_samples("random", 1'b0);
        finish_frame("random", 16'($urandom_range(0, 65535)), 2);
    endtask

    task automatic test_ignored_inputs();
        start_frame(16'sd3);
        check_samples("ignored", 1'b1);
        n_cmp++;
        if (result !== last_result || done !== 1'b0) begin
            n_err++;
            $display("FAIL ignored capture: result=%h done=%b, required %h 0",
                     result, done, last_result);
        end
        finish_frame("ignored", 16'h0042, 2);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL extra frame: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        start_frame(16'sd5);
        check_samples("b2b first", 1'b0);
        push_frame(16'sd7);
        res_q.push_back(16'h1234);
        res_rdy = 1'b1;
        res_in  = 16'h1234;
        start   = 1'b1;
        step    = 16'sd7;
        @(negedge clk);
        res_rdy = 1'b0;
        e = res_q.pop_front();
        n_cmp++;
        if (done !== 1'b1 || result !== e || valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b capture: done=%b result=%h valid=%b, required 1 %h 0",
                     done, result, valid, e);
        end
        last_result = e;
        @(posedge clk); #1;
        start = 1'b0;
        check_samples("b2b second", 1'b0);
        finish_frame("b2b second", 16'h5A5A, 1);
    endtask

    task automatic test_mid_reset();
        logic [15:0] e;
        start_frame(16'sd2);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (valid !== 1'b1 || din_out !== e) begin
                n_err++;
                $display("FAIL midrst sample %0d: valid=%b din_out=%h, required 1 %h",
                         i, valid, din_out, e);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (din_out !== 16'd0 || valid !== 1'b0 || result !== 16'd0 || done !== 1'b0 ||
            busy !== 1'b0 || timeout !== 1'b0 || state_dbg !== 2'd0) begin
            n_err++;
            $display("FAIL midrst abort: din=%h v=%b res=%h done=%b busy=%b to=%b st=%0d, required all 0",
                     din_out, valid, result, done, busy, timeout, state_dbg);
        end
        rst = 1'b1;
        exp_q.delete();
        last_result = 16'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL midrst idle: valid=%b busy=%b done=%b, required 0 0 0",
                     valid, busy, done);
        end
        start_frame(16'sd2);
        check_samples("midrst restart", 1'b0);
        finish_frame("midrst restart", 16'h0BAD, 1);
    endtask

    task automatic test_timeout();
`ifdef MAXMIN_STREAMER_TIMEOUT_EN
        start_frame(16'sd1);
        check_samples("timeout", 1'b0);
        for (int w = 2; w <= WM; w++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL timeout wait %0d: done=%b busy=%b, required 0 1", w, done, busy);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || timeout !== 1'b1 || result !== 16'h8000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout expiry: done=%b timeout=%b result=%h busy=%b, required 1 1 8000 0",
                     done, timeout, result, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout hold: done=%b timeout=%b, required 0 1", done, timeout);
        end
        start_frame(16'sd1);
        check_samples("timeout race", 1'b0);
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout clear on start: timeout=%b, required 0", timeout);
        end
        for (int w = 2; w <= WM; w++) @(negedge clk);
        res_q.push_back(16'h0ABC);
        res_rdy = 1'b1;
        res_in  = 16'h0ABC;
        @(negedge clk);
        res_rdy = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || timeout !== 1'b0 || result !== res_q[0]) begin
            n_err++;
            $display("FAIL timeout race capture: done=%b timeout=%b result=%h, required 1 0 %h",
                     done, timeout, result, res_q[0]);
        end
        last_result = res_q.pop_front();
`else
        start_frame(16'sd9);
        check_samples("no timeout", 1'b0);
        for (int w = 0; w < 3 * WM; w++) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL no timeout wait %0d: done=%b busy=%b timeout=%b, required 0 1 0",
                         w, done, busy, timeout);
            end
        end
        finish_frame("no timeout", 16'h00C3, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignored_inputs();
        test_back_to_back();
        test_mid_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
